// File: rtl/hex_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_entry_pkg
// Purpose  : Shared types and constants for the hex_entry block: entry FSM
//            state encoding and button index assignments.
// Revision : 1.0 - initial release
// ============================================================================
package hex_entry_pkg;

  // Entry FSM states; digit count is tracked separately so HOLD can keep 1 or 2.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Button bit positions within BTN[2:0].
  localparam int BTN_ENTER  = 0;
  localparam int BTN_COMMIT = 1;
  localparam int BTN_CLEAR  = 2;

  // Buttons are active-low; this is the idle (not pressed) level.
  localparam logic BTN_RELEASED = 1'b1;

endpackage : hex_entry_pkg
`default_nettype wire

// File: rtl/debounce_edge.sv
`default_nettype none
// ============================================================================
// Module   : debounce_edge
// Purpose  : One active-low button: 2-FF synchroniser, stability counter and
//            a single-cycle press pulse on an accepted released->pressed change.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_edge
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic btn_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync_meta;
  logic             r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Synchronise, count consecutive disagreeing cycles, accept the new level
  // once it has persisted long enough, and flag only the press direction.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_sync_meta <= BTN_RELEASED;
      r_sync      <= BTN_RELEASED;
      r_stable    <= BTN_RELEASED;
      r_cnt       <= '0;
      r_press     <= 1'b0;
    end else begin
      r_sync_meta <= btn_raw;
      r_sync      <= r_sync_meta;
      r_press     <= 1'b0;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
        r_press  <= (r_sync != BTN_RELEASED);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule : debounce_edge
`default_nettype wire

// File: rtl/hex_entry.sv
`default_nettype none
// ============================================================================
// Module   : hex_entry
// Purpose  : Debounces ENTER/COMMIT/CLEAR buttons, samples SW as a hex nibble
//            per ENTER, assembles up to two nibbles and offers the byte on a
//            valid/ready handshake.
// Config   : HEX_ENTRY_ECHO_EN adds echo_data (live view of the entry byte).
// Revision : 1.0 - initial release
// ============================================================================
module hex_entry
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [3:0] SW,
  input  logic [2:0] BTN,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] digit_cnt,
  output logic       busy
`ifdef HEX_ENTRY_ECHO_EN
  ,
  output logic [7:0] echo_data
`endif
);

  logic [3:0] r_sw_meta;
  logic [3:0] r_sw_sync;
  logic [2:0] w_press;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic [7:0] r_out_data;
  logic [7:0] w_out_data_nxt;
  logic [1:0] r_digit_cnt;
  logic [1:0] w_digit_cnt_nxt;

  // Two-stage synchroniser for the switch nibble.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= SW;
      r_sw_sync <= r_sw_meta;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      debounce_edge #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debounce (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .btn_raw (BTN[gi]),
        .press   (w_press[gi])
      );
    end
  endgenerate

  // Entry FSM and data registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state     <= EMPTY;
      r_shift     <= '0;
      r_out_data  <= '0;
      r_digit_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_out_data  <= w_out_data_nxt;
      r_digit_cnt <= w_digit_cnt_nxt;
    end
  end

  // Next-state logic; CLEAR beats COMMIT beats ENTER, and HOLD ignores
  // every button until the byte has been taken.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_out_data_nxt  = r_out_data;
    w_digit_cnt_nxt = r_digit_cnt;
    case (r_state)
      EMPTY, ONE, FULL: begin
        if (w_press[BTN_CLEAR]) begin
          w_state_nxt     = EMPTY;
          w_shift_nxt     = '0;
          w_digit_cnt_nxt = 2'd0;
        end else if (w_press[BTN_COMMIT]) begin
          if (r_state != EMPTY) begin
            w_state_nxt    = HOLD;
            w_out_data_nxt = r_shift;
          end
        end else if (w_press[BTN_ENTER]) begin
          if (r_state == EMPTY) begin
            w_state_nxt     = ONE;
            w_shift_nxt     = {4'h0, r_sw_sync};
            w_digit_cnt_nxt = 2'd1;
          end else if (r_state == ONE) begin
            w_state_nxt     = FULL;
            w_shift_nxt     = {r_shift[3:0], r_sw_sync};
            w_digit_cnt_nxt = 2'd2;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt     = EMPTY;
          w_shift_nxt     = '0;
          w_digit_cnt_nxt = 2'd0;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  assign out_data  = r_out_data;
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state == HOLD);
  assign digit_cnt = r_digit_cnt;

`ifdef HEX_ENTRY_ECHO_EN
  assign echo_data = r_shift;
`endif

endmodule : hex_entry
`default_nettype wire
